// File: rtl/mult_seq_pkg.sv
// Shared widths, state encoding and width helper for the wide-product sequencer.
package mult_seq_pkg;

  localparam int A_W     = 27;
  localparam int MB_W    = 18;
  localparam int CHUNK_W = 17;
  localparam int MP_W    = 45;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  function automatic int calc_pw(input int nchunk);
    return A_W + CHUNK_W * nchunk;
  endfunction

endpackage

// File: rtl/mult_seq_tagpipe.sv
// Valid/slice-index shift register that travels alongside the external multiplier.
module mult_seq_tagpipe #(
  parameter int LAT   = 0,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  generate
    if (LAT == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_vld = in_vld;
      assign out_idx = in_idx;
    end else begin : g_pipe
      logic [LAT-1:0]   vld_q;
      logic [IDX_W-1:0] idx_q [LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
        end else begin
          vld_q[0] <= in_vld;
          idx_q[0] <= in_idx;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign out_vld = vld_q[LAT-1];
      assign out_idx = idx_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/mult_seq_ctrl.sv
// Signed 27 x (17*NCHUNK) product sequenced through one shared 27x18 split multiplier.
// state | meaning
// IDLE  | waiting for an operand pair
// ISSUE | one B slice per cycle to the multiplier
// DRAIN | waiting MUL_LAT cycles for the last returns
// DONE  | product held on out_p until out_ready
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int NCHUNK  = 3,
  parameter int MUL_LAT = 0,
  localparam int BW = CHUNK_W * NCHUNK,
  localparam int PW = calc_pw(NCHUNK)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [A_W-1:0]  in_a,
  input  logic [BW-1:0]   in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   out_p,
  output logic            busy,
  output logic            mul_en,
  output logic [A_W-1:0]  mul_a,
  output logic [MB_W-1:0] mul_b,
  input  logic [MP_W-1:0] mul_p1,
  input  logic [MP_W-1:0] mul_p2
);

  localparam logic [1:0] LAST_K   = 2'(NCHUNK - 1);
  localparam logic [1:0] DRAIN_LD = 2'(MUL_LAT - 1);

  state_t             state, state_nxt;
  logic [A_W-1:0]     a_q;
  logic [BW-1:0]      b_q;
  logic [1:0]         k_q;
  logic [1:0]         drain_q;
  logic [PW-1:0]      acc_q;
  logic               tag_vld;
  logic [1:0]         tag_k;
  logic               last_k;
  logic [CHUNK_W-1:0] slice;
  logic               slice_msb;
  logic [MP_W:0]      psum;
  logic [PW-1:0]      psum_ext;

  assign last_k    = (k_q == LAST_K);
  assign slice     = CHUNK_W'(b_q >> (CHUNK_W * k_q));
  // only the top slice carries B's sign; lower slices are unsigned magnitudes
  assign slice_msb = last_k & b_q[BW-1];
  assign psum      = {mul_p1[MP_W-1], mul_p1} + {mul_p2[MP_W-1], mul_p2};
  assign psum_ext  = PW'($signed(psum));

  mult_seq_tagpipe #(
    .LAT   (MUL_LAT),
    .IDX_W (2)
  ) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (mul_en),
    .in_idx  (k_q),
    .out_vld (tag_vld),
    .out_idx (tag_k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ISSUE;
      ISSUE:   if (last_k) state_nxt = (MUL_LAT > 0) ? DRAIN : DONE;
      DRAIN:   if (drain_q == 2'd0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    mul_en    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    out_valid = 1'b0;
    out_p     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ISSUE: begin
        mul_en = 1'b1;
        mul_a  = a_q;
        mul_b  = {slice_msb, slice};
      end
      DONE: begin
        out_valid = 1'b1;
        out_p     = acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      drain_q <= '0;
      acc_q   <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q   <= in_a;
        b_q   <= in_b;
        k_q   <= '0;
        acc_q <= '0;
      end else begin
        if (tag_vld) acc_q <= acc_q + (psum_ext << (CHUNK_W * tag_k));
        if (state == ISSUE) k_q <= k_q + 2'd1;
      end
      if (state == ISSUE && last_k) drain_q <= DRAIN_LD;
      else if (state == DRAIN)      drain_q <= drain_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a default instance and a NCHUNK=4 / MUL_LAT=2 instance, each against a multiplier model.
module tb_mult_seq_ctrl;

  localparam int N0 = 3, L0 = 0, BW0 = 17*N0, PW0 = 27+BW0;
  localparam int N1 = 4, L1 = 2, BW1 = 17*N1, PW1 = 27+BW1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s, mul_en_s;
  logic [26:0]    in_a_s, mul_a_s;
  logic [BW0-1:0] in_b_s;
  logic [PW0-1:0] out_p_s;
  logic [17:0]    mul_b_s;
  logic [44:0]    mul_p1_s, mul_p2_s;

  logic           in_valid_w, in_ready_w, out_valid_w, out_ready_w, busy_w, mul_en_w;
  logic [26:0]    in_a_w, mul_a_w;
  logic [BW1-1:0] in_b_w;
  logic [PW1-1:0] out_p_w;
  logic [17:0]    mul_b_w;
  logic [44:0]    mul_p1_w, mul_p2_w;

  mult_seq_ctrl #(.NCHUNK(N0), .MUL_LAT(L0)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_a(in_a_s), .in_b(in_b_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_p(out_p_s), .busy(busy_s), .mul_en(mul_en_s), .mul_a(mul_a_s),
    .mul_b(mul_b_s), .mul_p1(mul_p1_s), .mul_p2(mul_p2_s));

  mult_seq_ctrl #(.NCHUNK(N1), .MUL_LAT(L1)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_a(in_a_w), .in_b(in_b_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_p(out_p_w), .busy(busy_w), .mul_en(mul_en_w), .mul_a(mul_a_w),
    .mul_b(mul_b_w), .mul_p1(mul_p1_w), .mul_p2(mul_p2_w));

  // split multiplier: a*b = a*b[8:0] + (a*signed(b[17:9]))<<9
  function automatic logic [44:0] mp1(input logic [26:0] a, input logic [17:0] b);
    logic signed [44:0] ax, lo;
    ax = 45'($signed(a));
    lo = 45'({1'b0, b[8:0]});
    return ax * lo;
  endfunction

  function automatic logic [44:0] mp2(input logic [26:0] a, input logic [17:0] b);
    logic signed [44:0] ax, hi;
    ax = 45'($signed(a));
    hi = 45'($signed(b[17:9]));
    return (ax * hi) << 9;
  endfunction

  assign mul_p1_s = mp1(mul_a_s, mul_b_s);
  assign mul_p2_s = mp2(mul_a_s, mul_b_s);

  logic [26:0] ra_w;
  logic [17:0] rb_w;
  logic [44:0] rp1_w, rp2_w;
  always @(posedge clk) begin
    if (mul_en_w) begin
      ra_w <= mul_a_w;
      rb_w <= mul_b_w;
    end
    rp1_w <= mp1(ra_w, rb_w);
    rp2_w <= mp2(ra_w, rb_w);
  end
  assign mul_p1_w = rp1_w;
  assign mul_p2_w = rp2_w;

  function automatic logic [PW0-1:0] ref_s(input logic [26:0] a, input logic [BW0-1:0] b);
    logic signed [PW0-1:0] ea, eb;
    ea = PW0'($signed(a));
    eb = PW0'($signed(b));
    return ea * eb;
  endfunction

  function automatic logic [PW1-1:0] ref_w(input logic [26:0] a, input logic [BW1-1:0] b);
    logic signed [PW1-1:0] ea, eb;
    ea = PW1'($signed(a));
    eb = PW1'($signed(b));
    return ea * eb;
  endfunction

  function automatic logic [17:0] exp_slice(input logic [BW0-1:0] b, input int k);
    logic [BW0-1:0] t;
    t = b >> (17 * k);
    return {(k == N0-1) ? b[BW0-1] : 1'b0, t[16:0]};
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic op_s(input logic [26:0] a, input logic [BW0-1:0] b, input int hold, input bit chk_mb);
    logic [17:0]    mbq[$];
    int             cyc;
    logic [PW0-1:0] expv;
    expv = ref_s(a, b);
    @(negedge clk);
    chk("in_ready_idle_s", in_ready_s, 1'b1);
    in_valid_s = 1'b1; in_a_s = a; in_b_s = b;
    @(negedge clk);
    in_valid_s = 1'b0;
    in_a_s = 27'($urandom);
    in_b_s = BW0'({$urandom, $urandom});
    chk("busy_s", busy_s, 1'b1);
    chk("in_ready_busy_s", in_ready_s, 1'b0);
    cyc = 1;
    while (!out_valid_s && cyc < 30) begin
      if (mul_en_s) mbq.push_back(mul_b_s);
      @(negedge clk);
      cyc++;
    end
    chk("latency_s", cyc, N0+L0+1);
    chk("out_p_s", out_p_s, expv);
    if (chk_mb) begin
      chk("mul_b_count", mbq.size(), N0);
      for (int k = 0; k < N0 && k < mbq.size(); k++)
        chk($sformatf("mul_b[%0d]", k), mbq[k], exp_slice(b, k));
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        in_valid_s = 1'b1; in_a_s = 27'd9; in_b_s = BW0'(11);
      end else begin
        in_valid_s = 1'b0;
      end
      @(negedge clk);
      chk("bp_out_valid", out_valid_s, 1'b1);
      chk("bp_out_p", out_p_s, expv);
      chk("bp_in_ready", in_ready_s, 1'b0);
    end
    in_valid_s = 1'b0;
    out_ready_s = 1'b1;
    @(negedge clk);
    out_ready_s = 1'b0;
    chk("in_ready_after_s", in_ready_s, 1'b1);
    chk("out_valid_after_s", out_valid_s, 1'b0);
    if (hold > 0) begin
      @(negedge clk);
      chk("pulse_ignored", busy_s, 1'b0);
    end
  endtask

  task automatic op_w(input logic [26:0] a, input logic [BW1-1:0] b, input string tag, input bit pre);
    int             cyc;
    logic [PW1-1:0] expv;
    expv = ref_w(a, b);
    if (!pre) @(negedge clk);
    in_valid_w = 1'b1; in_a_w = a; in_b_w = b;
    @(negedge clk);
    in_valid_w = 1'b0;
    in_a_w = 27'($urandom);
    in_b_w = BW1'({$urandom, $urandom, $urandom});
    cyc = 1;
    while (!out_valid_w && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, N1+L1+1);
    chk({tag, "_p"}, out_p_w, expv);
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
  endtask

  initial begin
    logic [PW1-1:0] q[$];
    logic [PW1-1:0] ev;
    int             got, cycles;

    rst = 1'b1;
    in_valid_s = 0; in_a_s = '0; in_b_s = '0; out_ready_s = 0;
    in_valid_w = 0; in_a_w = '0; in_b_w = '0; out_ready_w = 0;
    #12;
    chk("rst_in_ready", in_ready_s, 1'b1);
    chk("rst_out_valid", out_valid_s, 1'b0);
    chk("rst_busy", busy_s, 1'b0);
    chk("rst_mul_en", mul_en_s, 1'b0);
    chk("rst_out_p", out_p_s, '0);
    chk("rst_mul_a", mul_a_s, '0);
    chk("rst_mul_b", mul_b_s, '0);
    chk("rst_busy_w", busy_w, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    op_s(27'd3, BW0'(131071), 0, 1'b1);
    op_s(27'h7FFFFFF, {BW0{1'b1}}, 0, 1'b1);
    op_s(27'h4000000, {1'b1, {(BW0-1){1'b0}}}, 0, 1'b1);
    op_s(27'h3FFFFFF, {1'b0, {(BW0-1){1'b1}}}, 0, 1'b1);
    op_s(27'($urandom), BW0'({$urandom, $urandom}), 10, 1'b0);

    // abort in cycle 2 of an operation
    @(negedge clk);
    in_valid_s = 1'b1; in_a_s = 27'($urandom); in_b_s = BW0'({$urandom, $urandom});
    @(negedge clk);
    in_valid_s = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_s, 1'b0);
    chk("abort_in_ready", in_ready_s, 1'b1);
    chk("abort_mul_en", mul_en_s, 1'b0);
    chk("abort_mul_b", mul_b_s, '0);
    chk("abort_out_p", out_p_s, '0);
    @(negedge clk);
    rst = 1'b0;
    op_s(27'd5, BW0'(7), 0, 1'b1);

    for (int i = 0; i < 20; i++)
      op_s(27'($urandom), BW0'({$urandom, $urandom}), 0, 1'b1);

    op_w(27'($urandom), BW1'({$urandom, $urandom, $urandom}), "w_first", 1'b0);
    op_w(27'h4000000, {1'b1, {(BW1-1){1'b0}}}, "w_ext", 1'b0);

    // reset with returns in flight, next op accepted on the first edge after release
    @(negedge clk);
    in_valid_w = 1'b1; in_a_w = 27'($urandom); in_b_w = BW1'({$urandom, $urandom, $urandom});
    @(negedge clk);
    in_valid_w = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy_w", busy_w, 1'b0);
    chk("abort_mul_en_w", mul_en_w, 1'b0);
    #1;
    rst = 1'b0;
    op_w(27'd5, BW1'(7), "w_after_rst", 1'b1);

    got = 0;
    cycles = 0;
    @(negedge clk);
    while (got < 1000 && cycles < 40000) begin
      in_valid_w = ($urandom_range(0, 3) != 0);
      in_a_w = ($urandom_range(0, 7) == 0) ? 27'h4000000 : 27'($urandom);
      in_b_w = BW1'({$urandom, $urandom, $urandom});
      out_ready_w = ($urandom_range(0, 1) == 1);
      if (in_valid_w && in_ready_w) q.push_back(ref_w(in_a_w, in_b_w));
      if (out_valid_w && out_ready_w) begin
        ev = (q.size() != 0) ? q.pop_front() : 'x;
        chk($sformatf("rand_w[%0d]", got), out_p_w, ev);
        got++;
      end
      @(negedge clk);
      cycles++;
    end
    chk("rand_w_count", got, 1000);
    in_valid_w = 1'b0;
    out_ready_w = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer that computes a signed 27 x (17*NCHUNK)-bit product using one shared 27x18 split multiplier, which returns two 45-bit partial results whose sum is the product.
- Latches one operand pair, issues one 17-bit slice of B per cycle, aligns the returning partial products and shift-accumulates them.
- Presents the wide product on a valid/ready output.
- Sits between a wide-operand requester (e.g. a higher-precision MAC stage) and the multiplier instance; the multiplier itself is outside this block.

Parameters:
- NCHUNK, 3: number of 17-bit B slices (1..4); B width BW = 17*NCHUNK, product width PW = 27+BW.
- MUL_LAT, 0: multiplier latency in cycles (0 = combinational, 1 = registered inputs, max 2).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block can accept an operand pair.
- in_a, input, 27: signed multiplicand.
- in_b, input, BW: signed multiplier.
- out_valid, output, 1: product valid.
- out_ready, input, 1: consumer accepts the product.
- out_p, output, PW: signed product in_a*in_b.
- busy, output, 1: high in any state other than IDLE.
- mul_en, output, 1: slice issued this cycle; also drives the multiplier input-register enable.
- mul_a, output, 27: multiplier A operand.
- mul_b, output, 18: multiplier B operand.
- mul_p1, input, 45: partial result 1.
- mul_p2, input, 45: partial result 2.

Behaviour:
- Reset values (asynchronous on rst high):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; mul_en = 0.
  - out_p = 0, accumulator = 0, all counters and tag pipe = 0.
  - mul_a = 0, mul_b = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch A and B, clear the accumulator, set issue index k = 0, go to ISSUE.
  - ISSUE: mul_en = 1; mul_a = latched A; mul_b = slice k. k increments each cycle. After issuing slice NCHUNK-1: go to DRAIN if MUL_LAT > 0, else DONE.
  - DRAIN: mul_en = 0; stays exactly MUL_LAT cycles, counted by a down-counter, then goes to DONE.
  - DONE: out_valid = 1 and out_p = accumulator, both held stable. On out_ready, go to IDLE.
- Slice formation:
  - Slice k covers B bits [17k+16 : 17k].
  - For k < NCHUNK-1, mul_b = {1'b0, slice}, i.e. zero-extended and non-negative.
  - For k = NCHUNK-1, mul_b = {B[BW-1], slice}, i.e. sign-extended.
- Return alignment:
  - A tag pipe of depth MUL_LAT carries {valid, k} alongside the multiplier.
  - When the tag-pipe output is valid, accumulator += sign_extend_PW(mul_p1 + mul_p2) << (17*k_tag).
  - Compute the 46-bit sum mul_p1 + mul_p2 before shifting. The accumulator is PW bits; the final value is exact, with no saturation.
- Latency and throughput:
  - The accept edge is cycle 0.
  - out_valid rises in cycle NCHUNK + MUL_LAT + 1 (default: cycle 4).
  - No overlap between operations: in_ready is low from the accept edge until the cycle after the output handshake.
  - Minimum spacing between operations is NCHUNK + MUL_LAT + 2 cycles.
- Backpressure: out_ready low in DONE holds out_valid and out_p indefinitely; in_ready stays 0.
- in_valid outside IDLE is ignored and not queued.
- Reset mid-operation: rst aborts immediately to the reset values. Partial accumulation is discarded. Tags still in flight are cleared, so no stale multiplier return is accumulated after rst deasserts.
- in_a and in_b may change freely after the accept edge; only the latched copies are used.

Decomposition:
- Package mult_seq_pkg holds:
  - constants A_W = 27, MB_W = 18, CHUNK_W = 17, MP_W = 45;
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - a function for the PW width calculation.
- Sub-module mult_seq_tagpipe: MUL_LAT-deep valid/index shift register with asynchronous reset; a wire-through when MUL_LAT = 0.
- FSM and accumulator stay in mult_seq_ctrl.

Test Plan:
- Basic small values (defaults, multiplier model exact): in_a = 3, in_b = 131071 (0x1FFFF, slice 0 all ones) -> out_p = 393213 in cycle 4; mul_b sequence 0x1FFFF, 0, 0.
- Sign handling: in_a = -1, in_b = -1 -> out_p = 1; mul_b sequence 0x1FFFF, 0x1FFFF, 0x3FFFF.
- Extreme operands: in_a = -2^26, in_b = -2^50 -> out_p = 2^76. Then in_a = 2^26-1, in_b = 2^50-1 -> out_p = (2^26-1)*(2^50-1).
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_p stable, in_ready = 0, and an in_valid pulse is ignored. Release -> in_ready = 1 next cycle.
- Reset mid-operation: assert rst in cycle 2 of an operation -> all outputs at reset values immediately. A new op (5 x 7) after release -> out_p = 35 with no residue.
- Latency variant (MUL_LAT = 2, NCHUNK = 4): random 27 x 68 operands -> out_valid in cycle 7 with an exact product. Run 1000 back-to-back random ops with random out_ready; all results match the reference model.
